alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLen, default 32, operand/result width (legal: 8..64).
REQ-002 SHALL have parameter ShAmtW, default $clog2(XLen), shift-amount width derived from XLen (not overridden).
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  in  1  request valid.
REQ-006 SHALL have port ready_o  out  1  block can accept request.
REQ-007 SHALL have port a_i  in  XLen  operand A (signed or unsigned per op).
REQ-008 SHALL have port b_i  in  XLen  operand B; low ShAmtW bits are the shift amount for shifts.
REQ-009 SHALL have port alu_control_i  in  4  operation code (alu_op_e).
REQ-010 SHALL have port valid_o  out  1  result valid.
REQ-011 SHALL have port ready_i  in  1  consumer accepts result.
REQ-012 SHALL have port result_o  out  XLen  registered result.
REQ-013 SHALL have port zero_o  out  1  registered result == 0.
REQ-014 SHALL have port overflow_o  out  1  registered signed overflow, ADD/SUB only, else 0.

Function
REQ-015 Opcodes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL; 11-15 undefined -> result 0, overflow 0, zero 1.
REQ-016 SUB SHALL be A + ~B + 1 on one shared adder; SLT SHALL be sum MSB XOR overflow, zero-extended; SLTU SHALL be the inverted carry-out of A + ~B + 1.
REQ-017 Overflow SHALL be set when A and effective B share sign and sum sign differs; evaluated only for ADD/SUB.
REQ-018 FSM SHALL have states IDLE, BUSY, DONE.
REQ-019 Request SHALL be accepted on valid_i & ready_o; operands and opcode captured that edge.
REQ-020 ready_o SHALL be 1 in IDLE, and in DONE when ready_i = 1 (back-to-back), 0 in BUSY.
REQ-021 Non-MUL op: accept -> DONE; result_o/valid_o visible exactly 1 cycle after acceptance.
REQ-022 MUL (when compiled in): accept -> BUSY for XLen cycles of radix-2 shift-add -> DONE; valid_o asserted XLen+1 cycles after acceptance; result = low XLen bits of A*B (unsigned, equals signed low half).
REQ-023 In DONE, valid_o SHALL stay 1 and result_o/zero_o/overflow_o SHALL hold stable until ready_i = 1.
REQ-024 DONE & ready_i & ~valid_i SHALL go to IDLE; DONE & ready_i & valid_i SHALL accept the new request same edge with no bubble.
REQ-025 Shifts SHALL use b_i[ShAmtW-1:0] only; amount 0 returns A unchanged; SRA SHALL replicate A MSB.
REQ-026 valid_i while ready_o = 0 SHALL be ignored (requester must hold).
REQ-027 zero_o and overflow_o SHALL be computed from the final result, registered with result_o.

Reset
REQ-028 On rst_ni = 0, state SHALL go IDLE immediately; valid_o 0, result_o 0, zero_o 0, overflow_o 0, ready_o 1 after deassertion.
REQ-029 Reset during BUSY or DONE SHALL discard the operation; no valid_o for it after reset release.

Configuration
REQ-030 Macro ALU_MC_MUL_EN defined: MUL opcode 10 and multiplier datapath present per REQ-022.
REQ-031 Macro ALU_MC_MUL_EN undefined: opcode 10 SHALL behave as undefined (REQ-015), BUSY SHALL be unreachable, no multiplier logic synthesised.

Structure
REQ-032 Package alu_mc_pkg SHALL hold alu_op_e (4-bit enum), state enum, and the opcode width constant.
REQ-033 Multiplier SHALL be sub-module alu_mc_mul (start/done, XLen-cycle iterative), instantiated only under ALU_MC_MUL_EN.

Verification
REQ-034 Reset then SUB a=5, b=7, ready_i=1 -> next cycle valid_o=1, result 0xFFFFFFFE, zero 0, overflow 0.
REQ-035 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow 1; SLT a=0x80000000, b=1 -> 1; SLTU same operands -> 0.
REQ-036 SRA a=0x80000000, b=0x24 (amount 4) -> 0xF8000000; SLL a=1, b=31 -> 0x80000000.
REQ-037 ready_i held 0 for 5 cycles after XOR a=b=0xA5 -> valid_o=1, result 0, zero 1 stable all 5 cycles; back-to-back AND accepted on release edge.
REQ-038 With ALU_MC_MUL_EN: MUL a=0xFFFFFFFF, b=3 -> ready_o 0 for 32 cycles, valid_o at cycle 33, result 0xFFFFFFFD; rst_ni pulsed at cycle 10 -> no valid_o, IDLE.
REQ-039 Opcode 13 (and 10 without macro) a=1, b=1 -> 1-cycle latency, result 0, zero 1, overflow 0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: opcodes, FSM states, opcode width.
// Optional multiplier enabled by defining ALU_MC_MUL_EN.
package alu_mc_pkg;

  localparam int OpW = 4;

  typedef enum logic [OpW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Start/done handshake between the ALU core and its
// iterative multiplier (present only with ALU_MC_MUL_EN).
interface alu_mc_if #(
  parameter int XLen = 32
);
  logic            start;
  logic [XLen-1:0] a;
  logic [XLen-1:0] b;
  logic            done;
  logic [XLen-1:0] prod;

  modport master (
    output start, a, b,
    input  done, prod
  );

  modport slave (
    input  start, a, b,
    output done, prod
  );
endinterface

// File: rtl/alu_mc_mul.sv
// Radix-2 shift-add multiplier, XLen iterations per product.
// Instantiated by alu_mc only when ALU_MC_MUL_EN is defined.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int XLen = 32
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  alu_mc_if.slave bus
);

  localparam int CntW = $clog2(XLen + 1);

  logic [XLen-1:0] a_q, a_d;
  logic [XLen-1:0] b_q, b_d;
  logic [XLen-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLen-1:0] addend;

  assign addend = b_q[0] ? a_q : '0;

  // prod is the accumulator after the iteration in flight,
  // so the last step can be consumed on the edge it happens.
  assign bus.prod = acc_q + addend;
  assign bus.done = (cnt_q == CntW'(1));

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.start) begin
      a_d   = bus.a;
      b_d   = bus.b;
      acc_d = '0;
      cnt_d = CntW'(XLen);
    end else if (cnt_q != '0) begin
      acc_d = acc_q + addend;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and result sides.
// Define ALU_MC_MUL_EN to add the iterative MUL (opcode 10).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLen   = 32,
  parameter int ShAmtW = $clog2(XLen)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLen-1:0] a_i,
  input  logic [XLen-1:0] b_i,
  input  logic [OpW-1:0]  alu_control_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLen-1:0] result_o,
  output logic            zero_o,
  output logic            overflow_o
);

  localparam int M = XLen - 1;

  alu_op_e         op;
  state_e          state_q, state_d;
  logic [XLen-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic            is_mul;
  logic            mul_done;
  logic [XLen-1:0] mul_prod;

  logic            use_sub;
  logic [XLen-1:0] b_eff;
  logic [XLen:0]   sum_w;
  logic            add_ovf;
  logic [ShAmtW-1:0] sh;
  logic [XLen-1:0] alu_res;
  logic            alu_ovf;

  assign op      = alu_op_e'(alu_control_i);
  assign ready_o = (state_q == S_IDLE) |
                   ((state_q == S_DONE) & ready_i);
  assign accept  = valid_i & ready_o;
  assign valid_o = (state_q == S_DONE);

  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;

  // SUB, SLT and SLTU share one adder as A + ~B + 1.
  assign use_sub = (op == OP_SUB) |
                   (op == OP_SLT) |
                   (op == OP_SLTU);
  assign b_eff   = use_sub ? ~b_i : b_i;
  assign sum_w   = {1'b0, a_i} + {1'b0, b_eff} +
                   {{XLen{1'b0}}, use_sub};
  assign add_ovf = (a_i[M] == b_eff[M]) &
                   (sum_w[M] != a_i[M]);
  assign sh      = b_i[ShAmtW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum_w[M:0];
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = sum_w[M:0];
        alu_ovf = add_ovf;
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SLT:  alu_res = {{M{1'b0}}, sum_w[M] ^ add_ovf};
      OP_SLTU: alu_res = {{M{1'b0}}, ~sum_w[XLen]};
      OP_SLL:  alu_res = a_i << sh;
      OP_SRL:  alu_res = a_i >> sh;
      OP_SRA:  alu_res = $signed(a_i) >>> sh;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  alu_mc_if #(.XLen(XLen)) mul_if ();

  assign is_mul       = (op == OP_MUL);
  assign mul_if.start = accept & is_mul;
  assign mul_if.a     = a_i;
  assign mul_if.b     = b_i;
  assign mul_done     = mul_if.done;
  assign mul_prod     = mul_if.prod;

  alu_mc_mul #(.XLen(XLen)) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (mul_if)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept && is_mul) begin
          state_d = S_BUSY;
        end else if (accept) begin
          state_d  = S_DONE;
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ovf_d    = alu_ovf;
        end else if (state_q == S_DONE && ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mul_done) begin
          state_d  = S_DONE;
          result_d = mul_prod;
          zero_d   = (mul_prod == '0);
          ovf_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc; adds MUL scenarios when
// ALU_MC_MUL_EN is defined.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        o;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLen(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .a_i           (a),
    .b_i           (b),
    .alu_control_i (op),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .zero_o        (zero_o),
    .overflow_o    (overflow_o)
  );

  function automatic exp_t model(
    input logic [3:0] o_,
    input logic [31:0] x,
    input logic [31:0] y
  );
    exp_t   e;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.r = '0;
    e.o = 1'b0;
    e.lat = 1;
    case (o_)
      4'd0: begin
        e.r = x + y;
        s = sx + sy;
        e.o = (s > MAXS) || (s < MINS);
      end
      4'd1: begin
        e.r = x - y;
        s = sx - sy;
        e.o = (s > MAXS) || (s < MINS);
      end
      4'd2: e.r = x & y;
      4'd3: e.r = x | y;
      4'd4: e.r = x ^ y;
      4'd5: e.r = {31'd0, sx < sy};
      4'd6: e.r = {31'd0, x < y};
      4'd7: e.r = x << y[4:0];
      4'd8: e.r = x >> y[4:0];
      4'd9: e.r = $signed(x) >>> y[4:0];
`ifdef ALU_MC_MUL_EN
      4'd10: begin
        e.r = x * y;
        e.lat = 33;
      end
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic issue(
    input logic [3:0] o_,
    input logic [31:0] x,
    input logic [31:0] y
  );
    bit acc = 0;
    int n = 0;
    sb.push_back(model(o_, x, y));
    op = o_;
    a = x;
    b = y;
    valid_i = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_run++;
      n_fail++;
      $display("FAIL issue_timeout op=%0d", o_);
    end
  endtask

  task automatic collect(
    output logic [31:0] r,
    output logic z,
    output logic o,
    output int lat,
    output int rdy
  );
    lat = 0;
    rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!valid_o && ready_o) rdy++;
    end while (!valid_o && lat < 200);
    r = result_o;
    z = zero_o;
    o = overflow_o;
  endtask

  task automatic test_reset();
    n_run++;
    if ({valid_o, zero_o, overflow_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {valid_o, zero_o, overflow_o});
    end
    n_run++;
    if (result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result got %h want 0", result_o);
    end
    n_run++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", ready_o);
    end
  endtask

  task automatic run_one(
    input string nm,
    input logic [3:0] o_,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] r;
    logic z, o;
    int lat, rdy;
    exp_t e;
    issue(o_, x, y);
    collect(r, z, o, lat, rdy);
    e = sb.pop_front();
    n_run++;
    if (r !== e.r) begin
      n_fail++;
      $display("FAIL %s result got %h want %h", nm, r, e.r);
    end
    n_run++;
    if ({z, o} !== {e.z, e.o}) begin
      n_fail++;
      $display("FAIL %s zero/ovf got %b%b want %b%b",
               nm, z, o, e.z, e.o);
    end
    n_run++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL %s latency got %0d want %0d",
               nm, lat, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    ready_i = 1'b1;
    run_one("sub_5_7", 4'd1, 32'd5, 32'd7);
    run_one("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    run_one("slt", 4'd5, 32'h8000_0000, 32'd1);
    run_one("sltu", 4'd6, 32'h8000_0000, 32'd1);
    run_one("sra4", 4'd9, 32'h8000_0000, 32'h24);
    run_one("sll31", 4'd7, 32'd1, 32'd31);
    run_one("srl31", 4'd8, 32'h8000_0000, 32'h3F);
    run_one("sll0", 4'd7, 32'h1234_5678, 32'h40);
    run_one("sra0", 4'd9, 32'h8765_4321, 32'h0);
    run_one("sub_ovf", 4'd1, 32'h8000_0000, 32'd1);
    run_one("sub_zero", 4'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_one("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_one("or", 4'd3, 32'hF000_0001, 32'h0000_1000);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 9));
      run_one("rand", ro, $urandom, $urandom);
    end
  endtask

  task automatic test_undef();
    ready_i = 1'b1;
    run_one("op13", 4'd13, 32'd1, 32'd1);
    run_one("op11", 4'd11, 32'hFFFF_FFFF, 32'd7);
    run_one("op15", 4'd15, 32'h8000_0000, 32'h8000_0000);
`ifndef ALU_MC_MUL_EN
    run_one("op10_nomul", 4'd10, 32'd1, 32'd1);
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic z, o;
    int lat, rdy;
    exp_t e;
    ready_i = 1'b0;
    issue(4'd4, 32'hA5, 32'hA5);
    collect(r, z, o, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if ({valid_o, zero_o, result_o} !== {2'b11, 32'd0}) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got v%b z%b %h",
                 i, valid_o, zero_o, result_o);
      end
      @(posedge clk);
      @(negedge clk);
    end
    e = sb.pop_front();
    n_run++;
    if ({r, z, o, lat} !== {e.r, e.z, e.o, e.lat}) begin
      n_fail++;
      $display("FAIL stall_xor got %h %b%b %0d want %h",
               r, z, o, lat, e.r);
    end
    sb.push_back(model(4'd2, 32'hFF00_FF0F, 32'h0F0F_00FF));
    op = 4'd2;
    a = 32'hFF00_FF0F;
    b = 32'h0F0F_00FF;
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    n_run++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready got %b want 1", ready_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    collect(r, z, o, lat, rdy);
    e = sb.pop_front();
    n_run++;
    if ({r, z, o} !== {e.r, e.z, e.o}) begin
      n_fail++;
      $display("FAIL b2b_and got %h %b%b want %h %b%b",
               r, z, o, e.r, e.z, e.o);
    end
    n_run++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_latency got %0d want 1", lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic z, o;
    int lat, rdy;
    int seen = 0;
    ready_i = 1'b0;
    issue(4'd0, 32'd3, 32'd4);
    collect(r, z, o, lat, rdy);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    n_run++;
    if ({valid_o, result_o} !== 33'd0) begin
      n_fail++;
      $display("FAIL abort_async got v%b %h want 0",
               valid_o, result_o);
    end
    #2;
    rst_n = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o || !ready_o) seen++;
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_done bad cycles got %0d want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_MC_MUL_EN
  task automatic test_mul();
    logic [31:0] r;
    logic z, o;
    int lat, rdy;
    int seen = 0;
    exp_t e;
    ready_i = 1'b1;
    issue(4'd10, 32'hFFFF_FFFF, 32'd3);
    collect(r, z, o, lat, rdy);
    e = sb.pop_front();
    n_run++;
    if ({r, z, o} !== {e.r, e.z, e.o}) begin
      n_fail++;
      $display("FAIL mul_result got %h %b%b want %h",
               r, z, o, e.r);
    end
    n_run++;
    if (lat !== 33 || rdy !== 0) begin
      n_fail++;
      $display("FAIL mul_timing got lat %0d rdy %0d want 33 0",
               lat, rdy);
    end
    @(posedge clk);
    #1;
    run_one("mul_rand", 4'd10, $urandom, $urandom);
    run_one("mul_zero", 4'd10, 32'h1234, 32'd0);
    issue(4'd10, 32'd7, 32'd9);
    void'(sb.pop_front());
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o || !ready_o) seen++;
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mul_abort bad cycles got %0d want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    @(posedge clk);
    #1;
    test_ops();
    test_undef();
    test_back_to_back();
    test_reset_abort();
`ifdef ALU_MC_MUL_EN
    test_mul();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
